// File: rtl/jtframe_irq_arb.sv
// Interrupt arbiter: presents the highest-index enabled source to the CPU,
// clears its latch on the iack rising edge, then enforces a GAP-cycle hold-off.
module jtframe_irq_arb #(
  parameter int N   = 4,
  parameter int GAP = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] irq_in,
  input  logic [N-1:0] mask,
  input  logic         iack,
  output logic         int_n,
  output logic [2:0]   vector,
  output logic [N-1:0] clr,
  output logic         busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_GAP} state_t;

  state_t       state_q, state_d;
  logic         int_n_q, int_n_d;
  logic [2:0]   vector_q, vector_d;
  logic [N-1:0] clr_q, clr_d;
  logic         busy_q, busy_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         iack_l_q;

  logic [N-1:0] en, cur_oh;
  logic [2:0]   hi;
  logic         ack, cur_live;

  always_comb begin
    en     = irq_in & mask;
    hi     = '0;
    cur_oh = '0;
    // ascending scan so the highest set index wins
    for (int i = 0; i < N; i++) begin
      if (en[i]) hi = 3'(i);
      cur_oh[i] = (vector_q == 3'(i));
    end
    cur_live = |(en & cur_oh);
    ack      = iack & ~iack_l_q;

    state_d  = state_q;
    int_n_d  = int_n_q;
    vector_d = vector_q;
    clr_d    = '0;
    cnt_d    = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (|en) begin
          vector_d = hi;
          int_n_d  = 1'b0;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        // ack beats a simultaneous withdrawal
        if (ack) begin
          clr_d   = cur_oh;
          int_n_d = 1'b1;
          state_d = ST_WAIT;
        end else if (!cur_live) begin
          int_n_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!iack) begin
          cnt_d   = 4'(GAP - 1);
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (cnt_q == 4'd0) state_d = ST_IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      int_n_q  <= 1'b1;
      vector_q <= '0;
      clr_q    <= '0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      iack_l_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      int_n_q  <= int_n_d;
      vector_q <= vector_d;
      clr_q    <= clr_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      iack_l_q <= iack;
    end
  end

  assign int_n  = int_n_q;
  assign vector = vector_q;
  assign clr    = clr_q;
  assign busy   = busy_q;

endmodule

// File: doc/jtframe_irq_arb.md
JTFRAME_IRQ_ARB -- requirements
Module: jtframe_irq_arb

Interface
REQ-001 Parameter N, default 4: number of interrupt sources; legal range 1..8.
REQ-002 Parameter GAP, default 2: idle cycles enforced after iack release before a new request; legal range 1..15.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset is synchronous and active-high.
REQ-005 irq_in  input  N  latched per-source request flags, level, bit i = source i pending.
REQ-006 mask  input  N  per-source enable, 1 = source may be served.
REQ-007 iack  input  1  CPU interrupt-acknowledge level; only its rising edge acknowledges.
REQ-008 int_n  output  1  active-low interrupt request to CPU.
REQ-009 vector  output  3  index of the source currently being requested; upper unused bits 0 when N<8.
REQ-010 clr  output  N  one-cycle clear pulse, bit i clears source i's latch.
REQ-011 busy  output  1  high whenever the state is not IDLE.

Function
REQ-012 The block SHALL register iack every cycle into iack_l; ack event = iack & ~iack_l.
REQ-013 The FSM SHALL have exactly the states IDLE, REQ, WAIT and GAP.
REQ-014 In IDLE, if (irq_in & mask) != 0, the block SHALL load vector with the highest set index, drive int_n low and enter REQ on the same edge (1-cycle latency from request to int_n low).
REQ-015 In IDLE with no enabled request, int_n SHALL stay high; ack events SHALL be ignored (no clr, no state change).
REQ-016 In REQ, vector SHALL stay frozen; a higher-priority source arriving SHALL NOT pre-empt it.
REQ-017 In REQ, on an ack event the block SHALL pulse clr[vector] high for exactly one cycle, drive int_n high and enter WAIT.
REQ-018 In REQ, if irq_in[vector] or mask[vector] is low and no ack event occurs, the block SHALL drive int_n high, issue no clr and return to IDLE (request withdrawn).
REQ-019 If an ack event and withdrawal coincide in REQ, the ack SHALL take precedence (clr issued, enter WAIT).
REQ-020 An iack already high on entry to REQ SHALL NOT count as an ack; a fresh rising edge is required.
REQ-021 In WAIT, int_n SHALL stay high; when iack is low the block SHALL load a 4-bit counter with GAP-1 and enter GAP.
REQ-022 In GAP, the counter SHALL decrement once per cycle; when it is 0, the block SHALL enter IDLE on that edge, so exactly GAP cycles are spent in GAP.
REQ-023 clr SHALL be all-zero in every cycle except the single cycle after the accepting REQ-017 edge; at most one clr bit SHALL ever be high.
REQ-024 vector SHALL hold its last value outside REQ until the next capture.
REQ-025 busy SHALL equal (state != IDLE), registered with the state.

Reset
REQ-026 While rst is high at a clock edge: state = IDLE, int_n = 1, vector = 0, clr = 0, busy = 0, counter = 0, iack_l = 0.
REQ-027 Reset asserted mid-operation (any state) SHALL abandon the cycle without issuing clr; the source latch stays set and is re-served after reset.
REQ-028 No output SHALL change except on a clk rising edge, including during reset.

Verification
REQ-029 N=4, GAP=2, mask=4'hF, irq_in=4'b0010 -> next cycle int_n=0, vector=1; iack rises -> clr=4'b0010 for one cycle, int_n=1; iack falls -> 2 GAP cycles, then IDLE, busy=0.
REQ-030 irq_in=4'b1001 simultaneous -> vector=3; after ack of 3 with irq_in=4'b0001, the next request is issued with vector=0 exactly GAP cycles after iack fell, plus 1 cycle.
REQ-031 In REQ with vector=1, irq_in becomes 4'b0100 (source 1 drops) -> int_n=1, clr=0, back to IDLE, then new request with vector=2.
REQ-032 iack held high from before the request -> no clr and int_n stays low until iack falls and rises again.
REQ-033 Source withdrawal and iack rising in the same cycle -> clr[vector] pulses, enter WAIT.
REQ-034 rst pulsed while in REQ and again while in GAP -> all outputs at reset values next edge, clr never pulses, pending source re-requested after reset.
